sheila_bus_controller: RTL and testbench

//  Decodes the SHEILA page (&FExx) into active-low peripheral selects. Generates the CPU two-phase clock as PHI_2 plus a
//  CPU_EN strobe, both derived from the master clock. Stretches CPU cycles that address 1MHz-bus devices so each such

---
 rtl/sheila_bus_controller_if.sv | 51 +++++
 rtl/sheila_bus_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_sheila_bus_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sheila_bus_controller_if.sv
// ---------------------------------------------------------------------------
// sheila_bus_controller_if
//
// Purpose
//   Groups the CPU address bus, the derived CPU/peripheral timing strobes and
//   the active-low SHEILA peripheral selects into one bundle. It is shared by
//   the CPU core, the bus controller and the peripheral models.
//
// Signals
//   ADDRESS   [15:0]  CPU address bus (driven by the CPU side)
//   PHI_2             CPU phase-2 clock level
//   PHI_2_1M          1MHz peripheral bus phase-2 level
//   CPU_EN            one-CLK strobe in the last CLK of every CPU cycle
//   STRETCH           high while the current CPU cycle is stretched
//   nCRTC .. nTUBE    active-low peripheral selects
//
// Modports
//   master : CPU side; drives ADDRESS and observes timing and selects
//   slave  : bus controller; samples ADDRESS and drives timing and selects
// ---------------------------------------------------------------------------
interface sheila_bus_controller_if;
   logic [15:0] ADDRESS;
   logic        PHI_2;
   logic        PHI_2_1M;
   logic        CPU_EN;
   logic        STRETCH;
   logic        nCRTC;
   logic        nACIA;
   logic        nSERPROC;
   logic        nVULA;
   logic        nROMSEL;
   logic        nSVIA;
   logic        nUVIA;
   logic        nFDC;
   logic        nADC;
   logic        nTUBE;

   modport master (
      output ADDRESS,
      input  PHI_2, PHI_2_1M, CPU_EN, STRETCH,
      input  nCRTC, nACIA, nSERPROC, nVULA, nROMSEL,
      input  nSVIA, nUVIA, nFDC, nADC, nTUBE
   );

   modport slave (
      input  ADDRESS,
      output PHI_2, PHI_2_1M, CPU_EN, STRETCH,
      output nCRTC, nACIA, nSERPROC, nVULA, nROMSEL,
      output nSVIA, nUVIA, nFDC, nADC, nTUBE
   );
endinterface

// File: rtl/sheila_bus_controller.sv
// ---------------------------------------------------------------------------
// sheila_bus_controller
//
// Purpose
//   Decodes the SHEILA page (&FExx) into active-low peripheral selects and
//   generates the CPU timing (PHI_2 level plus CPU_EN strobe) from the 16MHz
//   master clock. CPU cycles that touch a 1MHz-bus device are stretched so the
//   access spans one complete 1MHz cycle (the high half of the cnt lap).
//
// Ports
//   CLK        in   master clock, 16MHz
//   nRESET     in   asynchronous, active-low reset
//   bus        slave modport of sheila_bus_controller_if
//                (ADDRESS in; PHI_2, PHI_2_1M, CPU_EN, STRETCH and the
//                 ten active-low selects out)
//   dbg_state  out  current FSM state (0 RUN, 1 WAIT1M, 2 SLOW)
//
// Timing
//   A free-running 4-bit counter cnt is the master time base; PHI_2_1M is
//   cnt[3]. Every output is a flop, so each *_d value is computed for the
//   NEXT count (cnt_d) and appears in the CLK where cnt equals that value.
//
//   CPU_EN semantics: CPU_EN is a single-CLK strobe marking the last CLK of a
//   CPU cycle. The CPU advances on every CLK where CPU_EN=1; there is no
//   back-pressure. The select and STRETCH of that cycle remain valid up to and
//   including the CPU_EN CLK and are released in the following CLK.
// ---------------------------------------------------------------------------
module sheila_bus_controller #(
   parameter logic [7:0]  SHEILA_PAGE = 8'hFE,
   parameter logic [15:0] SLOW_MASK   = 16'h30F3
) (
   input  logic                           CLK,
   input  logic                           nRESET,
   sheila_bus_controller_if.slave         bus,
   output logic [1:0]                     dbg_state
);

   // -----------------------------------------------------------------------
   // Select vector bit positions (active-low, 1 = deselected)
   // -----------------------------------------------------------------------
   localparam int SEL_CRTC    = 0;
   localparam int SEL_ACIA    = 1;
   localparam int SEL_SERPROC = 2;
   localparam int SEL_VULA    = 3;
   localparam int SEL_ROMSEL  = 4;
   localparam int SEL_SVIA    = 5;
   localparam int SEL_UVIA    = 6;
   localparam int SEL_FDC     = 7;
   localparam int SEL_ADC     = 8;
   localparam int SEL_TUBE    = 9;
   localparam int NUM_SEL     = 10;

   localparam logic [NUM_SEL-1:0] SEL_NONE = '1;

   // RUN    : normal 8-CLK CPU cycles aligned to cnt[2:0]==0
   // WAIT1M : slow access decoded; PHI_2 held low until the 1MHz high half
   // SLOW   : PHI_2 high for cnt 8..15, cycle ends at cnt 15
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_WAIT1M = 2'd1,
      ST_SLOW   = 2'd2
   } state_t;

   // -----------------------------------------------------------------------
   // State
   // -----------------------------------------------------------------------
   state_t               state_q,   state_d;
   logic [3:0]           cnt_q,     cnt_d;
   logic                 phi_2_q,   phi_2_d;
   logic                 cpu_en_q,  cpu_en_d;
   logic                 stretch_q, stretch_d;
   logic [NUM_SEL-1:0]   sel_n_q,   sel_n_d;

   // Decode of the live address bus
   logic [NUM_SEL-1:0]   dec_n;
   logic                 page_hit;
   logic                 slow_hit;
   logic [3:0]           blk;

   // -----------------------------------------------------------------------
   // Address decode (combinational; only latched at the sample point)
   // -----------------------------------------------------------------------
   assign blk      = bus.ADDRESS[7:4];
   assign page_hit = (bus.ADDRESS[15:8] == SHEILA_PAGE);
   // Stretch only on a SHEILA access; other pages never touch the 1MHz bus.
   assign slow_hit = page_hit & SLOW_MASK[blk];

   always_comb begin
      dec_n = SEL_NONE;
      if (page_hit) begin
         case (blk)
            4'h0: begin
               // &FE00-07 is the CRTC, &FE08-0F the ACIA
               if (bus.ADDRESS[3]) dec_n[SEL_ACIA] = 1'b0;
               else                dec_n[SEL_CRTC] = 1'b0;
            end
            4'h1:        dec_n[SEL_SERPROC] = 1'b0;
            4'h2:        dec_n[SEL_VULA]    = 1'b0;
            4'h3:        dec_n[SEL_ROMSEL]  = 1'b0;
            4'h4, 4'h5:  dec_n[SEL_SVIA]    = 1'b0;
            4'h6, 4'h7:  dec_n[SEL_UVIA]    = 1'b0;
            4'h8, 4'h9:  dec_n[SEL_FDC]     = 1'b0;
            4'hC, 4'hD:  dec_n[SEL_ADC]     = 1'b0;
            4'hE, 4'hF:  dec_n[SEL_TUBE]    = 1'b0;
            default:     dec_n = SEL_NONE;   // &FEA0-BF unmapped
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Next-state and registered-output logic
   // -----------------------------------------------------------------------
   always_comb begin
      cnt_d     = cnt_q + 4'd1;
      state_d   = state_q;
      sel_n_d   = sel_n_q;
      stretch_d = stretch_q;
      phi_2_d   = 1'b0;
      cpu_en_d  = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (cnt_q[2:0] == 3'd2) begin
               // Sample point: the decode is frozen for the rest of the cycle.
               sel_n_d = dec_n;
               if (slow_hit) begin
                  state_d   = ST_WAIT1M;
                  stretch_d = 1'b1;
               end
            end else if (cnt_q[2:0] == 3'd7) begin
               // CPU_EN CLK of a fast cycle: release for the new cycle.
               sel_n_d   = SEL_NONE;
               stretch_d = 1'b0;
            end
         end

         ST_WAIT1M: begin
            // Wait for the high half of the 1MHz cycle.
            if (cnt_q == 4'd7) begin
               state_d = ST_SLOW;
            end
         end

         ST_SLOW: begin
            if (cnt_q == 4'd15) begin
               state_d   = ST_RUN;
               sel_n_d   = SEL_NONE;
               stretch_d = 1'b0;
            end
         end

         default: begin
            state_d   = ST_RUN;
            sel_n_d   = SEL_NONE;
            stretch_d = 1'b0;
         end
      endcase

      // Output levels follow the state and count of the coming CLK.
      case (state_d)
         ST_RUN: begin
            phi_2_d  = cnt_d[2];
            cpu_en_d = (cnt_d[2:0] == 3'd7);
         end
         ST_WAIT1M: begin
            phi_2_d  = 1'b0;
            cpu_en_d = 1'b0;
         end
         ST_SLOW: begin
            phi_2_d  = cnt_d[3];
            cpu_en_d = (cnt_d == 4'd15);
         end
         default: begin
            phi_2_d  = 1'b0;
            cpu_en_d = 1'b0;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // Registers
   // -----------------------------------------------------------------------
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state_q   <= ST_RUN;
         cnt_q     <= 4'd0;
         phi_2_q   <= 1'b0;
         cpu_en_q  <= 1'b0;
         stretch_q <= 1'b0;
         sel_n_q   <= SEL_NONE;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         phi_2_q   <= phi_2_d;
         cpu_en_q  <= cpu_en_d;
         stretch_q <= stretch_d;
         sel_n_q   <= sel_n_d;
      end
   end

   // -----------------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------------
   assign bus.PHI_2    = phi_2_q;
   assign bus.PHI_2_1M = cnt_q[3];
   assign bus.CPU_EN   = cpu_en_q;
   assign bus.STRETCH  = stretch_q;

   assign bus.nCRTC    = sel_n_q[SEL_CRTC];
   assign bus.nACIA    = sel_n_q[SEL_ACIA];
   assign bus.nSERPROC = sel_n_q[SEL_SERPROC];
   assign bus.nVULA    = sel_n_q[SEL_VULA];
   assign bus.nROMSEL  = sel_n_q[SEL_ROMSEL];
   assign bus.nSVIA    = sel_n_q[SEL_SVIA];
   assign bus.nUVIA    = sel_n_q[SEL_UVIA];
   assign bus.nFDC     = sel_n_q[SEL_FDC];
   assign bus.nADC     = sel_n_q[SEL_ADC];
   assign bus.nTUBE    = sel_n_q[SEL_TUBE];

   assign dbg_state    = state_q;

endmodule

// File: tb/tb_sheila_bus_controller.sv
// ---------------------------------------------------------------------------
// tb_sheila_bus_controller
//
// Directed bench for sheila_bus_controller. The bench keeps its own copy of
// the 4-bit master count (cnt), advanced once per CLK, and all expected
// values are written per step from the documented timing of each scenario.
// Outputs are sampled 1 time unit after the rising CLK edge.
// ---------------------------------------------------------------------------
module tb_sheila_bus_controller;

   logic       CLK = 1'b0;
   logic       nRESET;
   logic [1:0] dbg_state;

   sheila_bus_controller_if bus ();

   sheila_bus_controller dut (
      .CLK       (CLK),
      .nRESET    (nRESET),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // 16MHz nominal; the absolute period is irrelevant to the logic.
   always #5 CLK = ~CLK;

   // Select vector in bit order CRTC..TUBE (bit 0 = nCRTC)
   logic [9:0] sel_n;
   assign sel_n = {bus.nTUBE, bus.nADC, bus.nFDC, bus.nUVIA, bus.nSVIA,
                   bus.nROMSEL, bus.nVULA, bus.nSERPROC, bus.nACIA, bus.nCRTC};

   localparam logic [9:0] S_NONE = 10'h3FF;
   localparam logic [9:0] S_ACIA = 10'h3FD;   // bit 1 low
   localparam logic [9:0] S_UVIA = 10'h3BF;   // bit 6 low
   localparam logic [9:0] S_FDC  = 10'h37F;   // bit 7 low
   localparam logic [9:0] S_ADC  = 10'h2FF;   // bit 8 low
   localparam logic [9:0] S_TUBE = 10'h1FF;   // bit 9 low

   int checks = 0;
   int errors = 0;
   int cnt    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s cnt=%0d observed=%0h expected=%0h", tag, cnt, obs, exp);
      end
   endtask

   // Advance one CLK and land just after the edge.
   task automatic step();
      @(posedge CLK);
      #1;
      cnt = (cnt + 1) % 16;
   endtask

   // Check the full visible output set against expected levels.
   task automatic chk_all(input string tag, input logic exp_phi, input logic exp_en,
                          input logic exp_str, input logic [9:0] exp_sel);
      chk({tag, ".phi2"},    {31'd0, bus.PHI_2},    {31'd0, exp_phi});
      chk({tag, ".cpu_en"},  {31'd0, bus.CPU_EN},   {31'd0, exp_en});
      chk({tag, ".stretch"}, {31'd0, bus.STRETCH},  {31'd0, exp_str});
      chk({tag, ".sel"},     {22'd0, sel_n},        {22'd0, exp_sel});
      chk({tag, ".phi2_1m"}, {31'd0, bus.PHI_2_1M}, (cnt >= 8) ? 32'd1 : 32'd0);
   endtask

   initial begin
      logic [9:0] exp_sel;
      int         k;

      // ---------------- 1: reset and first cycle ----------------
      nRESET      = 1'b0;
      bus.ADDRESS = 16'h1234;
      repeat (3) @(posedge CLK);
      #1;
      chk_all("rst", 1'b0, 1'b0, 1'b0, S_NONE);
      chk("rst.state", {30'd0, dbg_state}, 32'd0);
      nRESET = 1'b1;
      cnt    = 0;
      for (int i = 0; i < 8; i++) begin
         chk_all("first", (cnt >= 4), (cnt == 7), 1'b0, S_NONE);
         step();
      end

      // ---------------- 2: non-SHEILA address, plain cadence -----
      for (int i = 0; i < 24; i++) begin
         k = cnt % 8;
         chk_all("plain", (k >= 4), (k == 7), 1'b0, S_NONE);
         step();
      end
      // cnt is now 0

      // ---------------- 3: slow ACIA sampled at cnt 2 ------------
      bus.ADDRESS = 16'hFE08;
      for (int i = 0; i < 16; i++) begin
         // A late address change must not disturb the latched select.
         if (cnt == 5) bus.ADDRESS = 16'h1234;
         chk_all("acia", (cnt >= 8), (cnt == 15), (cnt >= 3), (cnt >= 3) ? S_ACIA : S_NONE);
         if (cnt == 5) chk("acia.state_wait", {30'd0, dbg_state}, 32'd1);
         if (cnt == 9) chk("acia.state_slow", {30'd0, dbg_state}, 32'd2);
         step();
      end

      // ---------------- 4: slow UVIA sampled at cnt 10 -----------
      for (int i = 0; i < 8; i++) begin
         chk_all("pre_uvia", (cnt >= 4), (cnt == 7), 1'b0, S_NONE);
         step();
      end
      bus.ADDRESS = 16'hFE60;
      for (int j = 0; j < 24; j++) begin
         if (j == 6) bus.ADDRESS = 16'h1234;
         chk_all("uvia", (j >= 16), (j == 23), (j >= 3), (j >= 3) ? S_UVIA : S_NONE);
         step();
      end
      // cnt is now 0; the new cycle must start clean
      chk_all("uvia_end", 1'b0, 1'b0, 1'b0, S_NONE);

      // ---------------- 5: fast TUBE, fast FDC, unmapped ---------
      for (int i = 0; i < 24; i++) begin
         k = i % 8;
         if (k == 0) begin
            case (i / 8)
               0:       bus.ADDRESS = 16'hFEE0;
               1:       bus.ADDRESS = 16'hFE80;
               default: bus.ADDRESS = 16'hFEA0;
            endcase
         end
         case (i / 8)
            0:       exp_sel = S_TUBE;
            1:       exp_sel = S_FDC;
            default: exp_sel = S_NONE;
         endcase
         chk_all("fast", (k >= 4), (k == 7), 1'b0, (k >= 3) ? exp_sel : S_NONE);
         step();
      end
      // cnt is now 8; idle one cycle to reach cnt 0
      bus.ADDRESS = 16'h1234;
      for (int i = 0; i < 8; i++) step();

      // ---------------- 6: reset during a slow ADC access --------
      bus.ADDRESS = 16'hFEC4;
      for (int i = 0; i < 11; i++) begin
         chk_all("adc", (cnt >= 8), 1'b0, (cnt >= 3), (cnt >= 3) ? S_ADC : S_NONE);
         step();
      end
      // cnt is 11, in SLOW
      chk("adc11.sel", {22'd0, sel_n}, {22'd0, S_ADC});
      chk("adc11.phi2", {31'd0, bus.PHI_2}, 32'd1);
      nRESET = 1'b0;
      #1;
      chk_all_reset: begin
         cnt = 0;
         chk_all("abort", 1'b0, 1'b0, 1'b0, S_NONE);
      end
      @(posedge CLK);
      #1;
      chk_all("abort_hold", 1'b0, 1'b0, 1'b0, S_NONE);
      bus.ADDRESS = 16'h1234;
      nRESET      = 1'b1;
      cnt         = 0;
      for (int i = 0; i < 16; i++) begin
         k = cnt % 8;
         chk_all("resume", (k >= 4), (k == 7), 1'b0, S_NONE);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
